// File: rtl/axi2mem_pkg.sv
// ---------------------------------------------------------------------------
// axi2mem_pkg
//   Shared definitions for the AXI4 to simple-memory bridge.
//   - AXI_LEN_WIDTH : width of the AXI burst length fields
//   - OKAY / SLVERR : AXI response codes returned on the R and B channels
//   - state_t       : bridge FSM states
//   - isSingleBeat  : true when an AXI len field describes one beat
// ---------------------------------------------------------------------------
package axi2mem_pkg;

    localparam int AXI_LEN_WIDTH = 8;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
        W_DRAIN,
        R_RESP,
        B_RESP
    } state_t;

    // AXI len encodes "beats minus one", so zero means a single beat.
    function automatic logic isSingleBeat(input logic [AXI_LEN_WIDTH-1:0] len);
        return (len == '0);
    endfunction

endpackage

// File: rtl/axi2mem_if.sv
// ---------------------------------------------------------------------------
// AXI_BUS
//   Reduced AXI4 bus carrying the five channels the bridge needs.
//   Parameters : AXI_ADDR_WIDTH, AXI_DATA_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH
//   Channels   : AW (id, addr, len), W (data, strb, last),
//                B (id, resp, user), AR (id, addr, len),
//                R (id, data, resp, last, user), each with valid/ready.
//   Modports   : Master drives requests and response readies,
//                Slave  drives request readies and responses.
// ---------------------------------------------------------------------------
interface AXI_BUS
    import axi2mem_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 16,
    parameter int AXI_USER_WIDTH = 10
);

    logic                         aw_valid;
    logic                         aw_ready;
    logic [AXI_ID_WIDTH-1:0]      aw_id;
    logic [AXI_ADDR_WIDTH-1:0]    aw_addr;
    logic [AXI_LEN_WIDTH-1:0]     aw_len;

    logic                         w_valid;
    logic                         w_ready;
    logic [AXI_DATA_WIDTH-1:0]    w_data;
    logic [AXI_DATA_WIDTH/8-1:0]  w_strb;
    logic                         w_last;

    logic                         b_valid;
    logic                         b_ready;
    logic [AXI_ID_WIDTH-1:0]      b_id;
    logic [1:0]                   b_resp;
    logic [AXI_USER_WIDTH-1:0]    b_user;

    logic                         ar_valid;
    logic                         ar_ready;
    logic [AXI_ID_WIDTH-1:0]      ar_id;
    logic [AXI_ADDR_WIDTH-1:0]    ar_addr;
    logic [AXI_LEN_WIDTH-1:0]     ar_len;

    logic                         r_valid;
    logic                         r_ready;
    logic [AXI_ID_WIDTH-1:0]      r_id;
    logic [AXI_DATA_WIDTH-1:0]    r_data;
    logic [1:0]                   r_resp;
    logic                         r_last;
    logic [AXI_USER_WIDTH-1:0]    r_user;

    modport Master (
        output aw_valid, aw_id, aw_addr, aw_len,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id, b_resp, b_user,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last, r_user,
        output r_ready
    );

    modport Slave (
        input  aw_valid, aw_id, aw_addr, aw_len,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id, b_resp, b_user,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last, r_user,
        input  r_ready
    );

endinterface

// File: rtl/axi2mem.sv
// ---------------------------------------------------------------------------
// axi2mem
//   Bridges single-beat AXI4 reads and writes onto a req/gnt/rvalid memory
//   port, one transaction at a time. Bursts are answered with SLVERR and
//   never reach the memory.
//
//   Ports
//     clk_i        : clock
//     rst_i        : synchronous active-high reset
//     AXI_Slave    : upstream AXI port (AXI_BUS.Slave)
//     mem_req_o    : memory request, held until mem_gnt_i
//     mem_gnt_i    : memory grant
//     mem_addr_o   : memory address (latched AXI address)
//     mem_we_o     : 1 = write, 0 = read
//     mem_be_o     : byte enables (all ones for reads)
//     mem_wdata_o  : write data
//     mem_rvalid_i : memory response valid, for reads and writes
//     mem_rdata_i  : memory read data
// ---------------------------------------------------------------------------
module axi2mem
    import axi2mem_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 16,
    parameter int AXI_USER_WIDTH = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    AXI_BUS.Slave                       AXI_Slave,
    output logic                        mem_req_o,
    input  logic                        mem_gnt_i,
    output logic [AXI_ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                        mem_we_o,
    output logic [AXI_DATA_WIDTH/8-1:0] mem_be_o,
    output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                        mem_rvalid_i,
    input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int BE_WIDTH = AXI_DATA_WIDTH / 8;

    state_t                       r_state;

    // Request register: everything the memory side needs, captured at
    // acceptance so the memory port stays stable however long grant takes.
    logic [AXI_ID_WIDTH-1:0]      r_id;
    logic [AXI_ADDR_WIDTH-1:0]    r_addr;
    logic                         r_we;
    logic [BE_WIDTH-1:0]          r_be;
    logic [AXI_DATA_WIDTH-1:0]    r_wdata;
    logic                         r_memReq;

    // Response register: read data and response code held for the AXI side
    // until the master takes them.
    logic [AXI_DATA_WIDTH-1:0]    r_rdata;
    logic [1:0]                   r_resp;
    logic                         r_rValid;
    logic                         r_bValid;

    logic                         w_isIdle;
    logic                         w_acceptWrite;
    logic                         w_acceptRead;

    // Acceptance decode. Readies follow the valids combinationally in IDLE so
    // a new transaction can be taken in the very first IDLE cycle. A write
    // needs AW and W together, and wins over a simultaneous read.
    always_comb begin
        w_isIdle      = (r_state == IDLE);
        w_acceptWrite = w_isIdle && AXI_Slave.aw_valid && AXI_Slave.w_valid;
        w_acceptRead  = w_isIdle && !w_acceptWrite && AXI_Slave.ar_valid;
    end

    // The bridge FSM. It owns both the request and the response registers so
    // every output apart from the acceptance readies is a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_id     <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_memReq <= 1'b0;
            r_rdata  <= '0;
            r_resp   <= OKAY;
            r_rValid <= 1'b0;
            r_bValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acceptWrite) begin
                        r_id    <= AXI_Slave.aw_id;
                        r_addr  <= AXI_Slave.aw_addr;
                        r_we    <= 1'b1;
                        r_be    <= AXI_Slave.w_strb;
                        r_wdata <= AXI_Slave.w_data;
                        if (isSingleBeat(AXI_Slave.aw_len)) begin
                            r_resp   <= OKAY;
                            r_memReq <= 1'b1;
                            r_state  <= MEM_REQ;
                        end else begin
                            // A malformed burst whose first beat is already
                            // last has nothing left to drain.
                            r_resp <= SLVERR;
                            if (AXI_Slave.w_last) begin
                                r_bValid <= 1'b1;
                                r_state  <= B_RESP;
                            end else begin
                                r_state  <= W_DRAIN;
                            end
                        end
                    end else if (w_acceptRead) begin
                        r_id    <= AXI_Slave.ar_id;
                        r_addr  <= AXI_Slave.ar_addr;
                        r_we    <= 1'b0;
                        r_be    <= '1;
                        r_wdata <= '0;
                        if (isSingleBeat(AXI_Slave.ar_len)) begin
                            r_resp   <= OKAY;
                            r_memReq <= 1'b1;
                            r_state  <= MEM_REQ;
                        end else begin
                            r_resp   <= SLVERR;
                            r_rdata  <= '0;
                            r_rValid <= 1'b1;
                            r_state  <= R_RESP;
                        end
                    end
                end

                MEM_REQ: begin
                    if (mem_gnt_i) begin
                        r_memReq <= 1'b0;
                        r_state  <= MEM_WAIT;
                    end
                end

                MEM_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (r_we) begin
                            r_bValid <= 1'b1;
                            r_state  <= B_RESP;
                        end else begin
                            r_rdata  <= mem_rdata_i;
                            r_rValid <= 1'b1;
                            r_state  <= R_RESP;
                        end
                    end
                end

                W_DRAIN: begin
                    if (AXI_Slave.w_valid && AXI_Slave.w_last) begin
                        r_bValid <= 1'b1;
                        r_state  <= B_RESP;
                    end
                end

                R_RESP: begin
                    if (AXI_Slave.r_ready) begin
                        r_rValid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end

                B_RESP: begin
                    if (AXI_Slave.b_ready) begin
                        r_bValid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // AXI handshake outputs. W stays ready through a rejected burst so the
    // master can finish pushing its beats.
    assign AXI_Slave.aw_ready = w_acceptWrite;
    assign AXI_Slave.w_ready  = w_acceptWrite || (r_state == W_DRAIN);
    assign AXI_Slave.ar_ready = w_acceptRead;

    // Responses come straight from the registers; every response is one beat.
    assign AXI_Slave.r_valid  = r_rValid;
    assign AXI_Slave.r_id     = r_id;
    assign AXI_Slave.r_data   = r_rdata;
    assign AXI_Slave.r_resp   = r_resp;
    assign AXI_Slave.r_last   = 1'b1;
    assign AXI_Slave.r_user   = {AXI_USER_WIDTH{1'b0}};

    assign AXI_Slave.b_valid  = r_bValid;
    assign AXI_Slave.b_id     = r_id;
    assign AXI_Slave.b_resp   = r_resp;
    assign AXI_Slave.b_user   = {AXI_USER_WIDTH{1'b0}};

    // Memory port driven from the request register.
    assign mem_req_o   = r_memReq;
    assign mem_addr_o  = r_addr;
    assign mem_we_o    = r_we;
    assign mem_be_o    = r_be;
    assign mem_wdata_o = r_wdata;

    // Only one transaction is ever in flight, so at most one response
    // channel can be active.
    assert property (@(posedge clk_i) disable iff (rst_i) !(r_rValid && r_bValid));

endmodule

// File: tb/tb_axi2mem.sv
// ---------------------------------------------------------------------------
// tb_axi2mem
//   Drives axi2mem with directed and random single-beat and burst traffic.
//   A behavioural memory answers the memory port; a transaction-level word
//   store predicts every read response.
// ---------------------------------------------------------------------------
module tb_axi2mem;

    localparam logic [1:0] RESP_OK  = 2'b00;
    localparam logic [1:0] RESP_ERR = 2'b10;

    logic        clk;
    logic        rst;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int totalCnt = 0;
    int badCnt   = 0;

    // Expectations for the memory port, set by the transaction tasks.
    logic [31:0] expAddr  = '0;
    logic        expWe    = 1'b0;
    logic [3:0]  expBe    = '0;
    logic [31:0] expWdata = '0;

    // Responder knobs: -1 picks a random delay.
    int gntWait     = -1;
    int rvalidDelay = -1;

    int memAccessCount = 0;
    int lastAcceptWait = 0;
    int rHs = 0, bHs = 0, arHs = 0, wHs = 0, rValidSeen = 0, bValidSeen = 0;

    logic [31:0] refMem [logic [31:0]];
    logic [31:0] devMem [logic [31:0]];

    AXI_BUS #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .AXI_ID_WIDTH(16),
        .AXI_USER_WIDTH(10)
    ) bus ();

    axi2mem #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .AXI_ID_WIDTH(16),
        .AXI_USER_WIDTH(10)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .AXI_Slave(bus),
        .mem_req_o(mem_req_o),
        .mem_gnt_i(mem_gnt_i),
        .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Contents of a word never written: a fixed scramble of its address.
    function automatic logic [31:0] defaultWord(input logic [31:0] addr);
        return (addr * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] refWord(input logic [31:0] addr);
        return refMem.exists(addr) ? refMem[addr] : defaultWord(addr);
    endfunction

    function automatic logic [31:0] devWord(input logic [31:0] addr);
        return devMem.exists(addr) ? devMem[addr] : defaultWord(addr);
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                               input logic [3:0] be);
        logic [31:0] res = oldW;
        for (int b = 0; b < 4; b++)
            if (be[b]) res[8*b +: 8] = newW[8*b +: 8];
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        totalCnt++;
        if (actual !== expected) begin
            badCnt++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Handshake monitor, sampled mid-cycle where every signal is settled.
    always @(negedge clk) begin
        if (bus.r_valid && bus.r_ready)   rHs++;
        if (bus.b_valid && bus.b_ready)   bHs++;
        if (bus.ar_valid && bus.ar_ready) arHs++;
        if (bus.w_valid && bus.w_ready)   wHs++;
        if (bus.r_valid) rValidSeen++;
        if (bus.b_valid) bValidSeen++;
    end

    // Behavioural memory: grants after a chosen delay, answers one or more
    // cycles after the grant, and checks the request is stable while waiting.
    initial begin : responder
        int reqCycles = 0;
        int gntLimit  = 0;
        int waitCnt   = 0;
        bit owe       = 0;
        bit gntDriven = 0;
        logic [31:0] pAddr = '0, pWdata = '0;
        logic [3:0]  pBe = '0;
        logic        pWe = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            if (gntDriven) begin
                gntDriven = 0;
                mem_gnt_i = 1'b0;
                memAccessCount++;
                if (pWe) devMem[pAddr] = mergeBytes(devWord(pAddr), pWdata, pBe);
                owe     = 1;
                waitCnt = (rvalidDelay >= 0) ? rvalidDelay : $urandom_range(0, 2);
            end
            if (owe) begin
                if (waitCnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = pWe ? $urandom : devWord(pAddr);
                    owe = 0;
                end else begin
                    waitCnt--;
                end
            end
            if (mem_req_o) begin
                if (reqCycles == 0) gntLimit = (gntWait >= 0) ? gntWait : $urandom_range(0, 3);
                checkOutput("memAddr", mem_addr_o, expAddr);
                if (reqCycles >= gntLimit) begin
                    checkOutput("memWe", mem_we_o, expWe);
                    checkOutput("memBe", mem_be_o, expBe);
                    if (expWe) checkOutput("memWdata", mem_wdata_o, expWdata);
                    pAddr = mem_addr_o; pWe = mem_we_o; pBe = mem_be_o; pWdata = mem_wdata_o;
                    mem_gnt_i = 1'b1;
                    gntDriven = 1;
                    reqCycles = 0;
                end else begin
                    reqCycles++;
                end
            end else begin
                reqCycles = 0;
            end
        end
    end

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic acceptWrite(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [31:0] data, input logic [3:0] strb);
        int cyc = 0;
        bus.aw_valid = 1'b1; bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len;
        bus.w_valid = 1'b1; bus.w_data = data; bus.w_strb = strb; bus.w_last = (len == 0);
        do begin @(negedge clk); cyc++; end while (!bus.aw_ready && cyc < 50);
        lastAcceptWait = cyc;
        checkOutput("awAccept", {bus.aw_ready, bus.w_ready}, 2'b11);
        if (bus.aw_ready) checkOutput("arHeld", bus.ar_ready, 1'b0);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.w_last = 1'b0;
    endtask

    task automatic drainWrite(input int beats);
        for (int k = 1; k <= beats; k++) begin
            int cyc = 0;
            bus.w_valid = 1'b1; bus.w_data = $urandom; bus.w_strb = 4'hF; bus.w_last = (k == beats);
            do begin @(negedge clk); cyc++; end while (!bus.w_ready && cyc < 50);
            checkOutput("wDrain", bus.w_ready, 1'b1);
            @(posedge clk); #1;
            bus.w_valid = 1'b0; bus.w_last = 1'b0;
        end
    endtask

    task automatic acceptRead(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len);
        int cyc = 0;
        bus.ar_valid = 1'b1; bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len;
        do begin @(negedge clk); cyc++; end while (!bus.ar_ready && cyc < 50);
        lastAcceptWait = cyc;
        checkOutput("arAccept", bus.ar_ready, 1'b1);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
    endtask

    task automatic collectB(input logic [15:0] id, input logic [1:0] resp, input int hold);
        int cyc = 0;
        while (!bus.b_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        checkOutput("bValid", bus.b_valid, 1'b1);
        repeat (hold) begin @(posedge clk); #1; checkOutput("bHold", bus.b_valid, 1'b1); end
        checkOutput("bId", bus.b_id, id);
        checkOutput("bResp", bus.b_resp, resp);
        checkOutput("bUser", bus.b_user, 10'd0);
        bus.b_ready = 1'b1;
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
        checkOutput("bDone", bus.b_valid, 1'b0);
    endtask

    task automatic collectR(input logic [15:0] id, input logic [31:0] data, input logic [1:0] resp,
                            input int hold);
        int cyc = 0;
        while (!bus.r_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        checkOutput("rValid", bus.r_valid, 1'b1);
        repeat (hold) begin
            @(posedge clk); #1;
            checkOutput("rHold", bus.r_valid, 1'b1);
            checkOutput("rHoldData", bus.r_data, data);
        end
        checkOutput("rId", bus.r_id, id);
        checkOutput("rData", bus.r_data, data);
        checkOutput("rResp", bus.r_resp, resp);
        checkOutput("rLast", bus.r_last, 1'b1);
        checkOutput("rUser", bus.r_user, 10'd0);
        bus.r_ready = 1'b1;
        @(posedge clk); #1;
        bus.r_ready = 1'b0;
        checkOutput("rDone", bus.r_valid, 1'b0);
    endtask

    task automatic doWrite(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] data, input logic [3:0] strb, input int hold);
        int acc0 = memAccessCount;
        int w0   = wHs;
        int b0   = bHs;
        expAddr = addr; expWe = 1'b1; expBe = strb; expWdata = data;
        acceptWrite(id, addr, len, data, strb);
        if (len != 0) drainWrite(len);
        collectB(id, (len == 0) ? RESP_OK : RESP_ERR, hold);
        checkOutput("wrAccess", memAccessCount - acc0, (len == 0) ? 1 : 0);
        checkOutput("wrBeats", wHs - w0, len + 1);
        checkOutput("wrBHs", bHs - b0, 1);
        if (len == 0) refMem[addr] = mergeBytes(refWord(addr), data, strb);
    endtask

    task automatic doRead(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input int hold);
        int acc0 = memAccessCount;
        int r0   = rHs;
        int a0   = arHs;
        expAddr = addr; expWe = 1'b0; expBe = 4'hF;
        acceptRead(id, addr, len);
        collectR(id, (len == 0) ? refWord(addr) : 32'h0, (len == 0) ? RESP_OK : RESP_ERR, hold);
        checkOutput("rdAccess", memAccessCount - acc0, (len == 0) ? 1 : 0);
        checkOutput("rdRHs", rHs - r0, 1);
        checkOutput("rdArHs", arHs - a0, 1);
    endtask

    initial begin : main
        int acc0, cyc, rv0, bv0;
        bus.aw_valid = 1'b0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
        bus.w_valid = 1'b0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0;
        bus.ar_valid = 1'b0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;
        bus.r_ready = 1'b0; bus.b_ready = 1'b0;
        rst = 1'b1;
        applyStimulus(3);
        rst = 1'b0;
        applyStimulus(1);

        // Reset state.
        checkOutput("rstReq", mem_req_o, 1'b0);
        checkOutput("rstReadies", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b000);
        checkOutput("rstValids", {bus.r_valid, bus.b_valid}, 2'b00);
        checkOutput("rstMem", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}, '0);

        // Single read with immediate grant.
        refMem[32'h100] = 32'hDEADBEEF;
        devMem[32'h100] = 32'hDEADBEEF;
        gntWait = 0;
        doRead(16'd5, 32'h100, 8'd0, 0);

        // Single write with partial strobes, then read it back.
        doWrite(16'h0A5C, 32'h200, 8'd0, 32'h12345678, 4'b0011, 0);
        doRead(16'd6, 32'h200, 8'd0, 0);
        gntWait = -1;

        // Write and read offered together: the write goes first.
        bus.ar_valid = 1'b1; bus.ar_id = 16'd7; bus.ar_addr = 32'h300; bus.ar_len = 8'd0;
        expAddr = 32'h304; expWe = 1'b1; expBe = 4'hF; expWdata = 32'hCAFEF00D;
        acceptWrite(16'd8, 32'h304, 8'd0, 32'hCAFEF00D, 4'hF);
        refMem[32'h304] = 32'hCAFEF00D;
        rv0 = arHs;
        collectB(16'd8, RESP_OK, 1);
        checkOutput("arAfterB", arHs - rv0, 0);
        doRead(16'd7, 32'h300, 8'd0, 0);

        // Bursts are rejected without touching memory.
        doWrite(16'd9, 32'h400, 8'd3, 32'h11112222, 4'hF, 0);
        doRead(16'd10, 32'h400, 8'd1, 0);

        // Backpressure on grant and on the R and B channels.
        gntWait = 5;
        doRead(16'd11, 32'h104, 8'd0, 3);
        doWrite(16'd12, 32'h108, 8'd0, 32'h0BADF00D, 4'b1101, 3);
        gntWait = -1;

        // Reset while waiting for the memory; its late response must vanish.
        gntWait = 0; rvalidDelay = 8;
        expAddr = 32'h500; expWe = 1'b0; expBe = 4'hF;
        acc0 = memAccessCount;
        acceptRead(16'd13, 32'h500, 8'd0);
        cyc = 0;
        while (memAccessCount == acc0 && cyc < 50) begin applyStimulus(1); cyc++; end
        checkOutput("rstGrant", memAccessCount - acc0, 1);
        applyStimulus(1);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        checkOutput("rstMidMem", {mem_addr_o, mem_we_o, mem_be_o, mem_req_o}, '0);
        rv0 = rValidSeen; bv0 = bValidSeen;
        applyStimulus(12);
        checkOutput("rstNoResp", (rValidSeen - rv0) + (bValidSeen - bv0), 0);
        rvalidDelay = -1; gntWait = -1;
        doRead(16'd14, 32'h200, 8'd0, 0);
        checkOutput("rstIdleAccept", lastAcceptWait, 1);

        // Randomised mix over a small address pool.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] addr = 32'h1000 + ($urandom_range(0, 7) << 2);
            logic [15:0] id = 16'($urandom);
            int hold = $urandom_range(0, 2);
            case ($urandom_range(0, 5))
                0, 1: doWrite(id, addr, 8'd0, $urandom, 4'($urandom), hold);
                2, 3: doRead(id, addr, 8'd0, hold);
                4:    doWrite(id, addr, 8'($urandom_range(1, 4)), $urandom, 4'hF, hold);
                default: doRead(id, addr, 8'($urandom_range(1, 3)), hold);
            endcase
        end

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule

// File: doc/axi2mem.md
AXI2MEM -- requirements
Module: axi2mem

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, address width of the AXI and memory sides.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data width of both sides; only 32 is supported.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 16, AXI ID width.
REQ-004 SHALL have parameter AXI_USER_WIDTH, default 10, AXI user width.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk_i, input, 1, the clock.
REQ-007 SHALL have port rst_i, input, 1, the synchronous active-high reset.
REQ-008 SHALL have port AXI_Slave, AXI_BUS.Slave modport, parameterised, the upstream AXI4 port driven by the core-side AXI master.
REQ-009 SHALL have port mem_req_o, output, 1, memory request.
REQ-010 SHALL have port mem_gnt_i, input, 1, memory grant.
REQ-011 SHALL have port mem_addr_o, output, AXI_ADDR_WIDTH, memory address.
REQ-012 SHALL have port mem_we_o, output, 1, write enable.
REQ-013 SHALL have port mem_be_o, output, AXI_DATA_WIDTH/8, byte enables.
REQ-014 SHALL have port mem_wdata_o, output, AXI_DATA_WIDTH, write data.
REQ-015 SHALL have port mem_rvalid_i, input, 1, response valid (reads and writes).
REQ-016 SHALL have port mem_rdata_i, input, AXI_DATA_WIDTH, read data.

Function
REQ-017 SHALL implement an FSM with states IDLE, MEM_REQ, MEM_WAIT, W_DRAIN, R_RESP and B_RESP, and SHALL hold one transaction at a time.
REQ-018 In IDLE, when aw_valid and w_valid are both 1, SHALL assert aw_ready and w_ready in the same cycle and latch aw_id, aw_addr, aw_len, w_data and w_strb.
- Write SHALL have priority over a simultaneous ar_valid.
- aw_valid alone SHALL NOT be accepted.
REQ-019 In IDLE, with no acceptable write and ar_valid=1, SHALL assert ar_ready and latch ar_id, ar_addr and ar_len.
REQ-020 After an accepted write with aw_len=0, or a read with ar_len=0, SHALL go to MEM_REQ next cycle.
REQ-021 In MEM_REQ, SHALL drive mem_req_o=1 with stable address, we, be and wdata; reads SHALL drive mem_be_o all ones.
- On mem_gnt_i=1 SHALL deassert mem_req_o the next cycle and go to MEM_WAIT.
REQ-022 In MEM_WAIT, on mem_rvalid_i=1, SHALL register mem_rdata_i for reads and go to R_RESP (read) or B_RESP (write).
- mem_rvalid_i SHALL be legal in the cycle after the grant or later.
REQ-023 In R_RESP, SHALL drive r_valid=1, r_last=1, r_resp=OKAY and r_id=latched ID, with r_data held stable; on r_ready=1 SHALL go to IDLE.
REQ-024 In B_RESP, SHALL drive b_valid=1, b_resp=OKAY and b_id=latched ID; on b_ready=1 SHALL go to IDLE.
REQ-025 Bursts (len≠0) SHALL be rejected without any memory access.
- A read burst SHALL go to R_RESP with r_resp=SLVERR, r_data=0 and a single beat with r_last=1.
- A write burst SHALL go to W_DRAIN, hold w_ready=1 until a beat with w_last=1 is accepted, then go to B_RESP with b_resp=SLVERR.
REQ-026 Response valids SHALL stay asserted until the handshake completes, and SHALL NOT depend combinationally on r_ready or b_ready.
REQ-027 A transaction SHALL take at least 4 cycles from acceptance to IDLE, with zero idle cycles before the next acceptance.
REQ-028 r_user and b_user SHALL be 0.

Reset
REQ-029 While rst_i=1 at a clock edge, SHALL enter IDLE and clear all latched fields to 0.
REQ-030 After reset, SHALL drive all of the following to 0: mem_req_o, aw_ready, w_ready, ar_ready, r_valid, b_valid, and the mem_*_o data and address outputs.
REQ-031 A reset during any state, including a granted-but-unanswered memory access, SHALL abandon the transaction.
- A late mem_rvalid_i arriving in IDLE SHALL be ignored.

Structure
REQ-032 A shared package axi2mem_pkg SHALL hold the state enum and the resp constants OKAY=2'b00 and SLVERR=2'b10.
REQ-033 No sub-module SHALL be used; the block is a single FSM plus a request register and a response register.

Verification
REQ-034 Single read: AR addr=0x100, id=5, len=0; mem_gnt_i next cycle; rvalid with rdata=0xDEADBEEF -> one R beat with id=5, data=0xDEADBEEF, OKAY, last=1.
REQ-035 Single write: AW+W together, addr=0x200, data=0x12345678, strb=4'b0011 -> mem_we_o=1 and be=0011 on the memory side; B with id matching and OKAY.
REQ-036 AR and AW+W asserted in the same cycle -> write served first; the read is accepted only after B completes.
REQ-037 Write burst aw_len=3 -> 4 W beats accepted, mem_req_o never asserted, b_resp=SLVERR; read burst ar_len=1 -> one R beat with SLVERR and data=0.
REQ-038 Backpressure: mem_gnt_i low for 5 cycles, then r_ready low for 3 cycles -> address and data stay stable throughout, and exactly one handshake occurs on each channel.
REQ-039 rst_i pulsed in MEM_WAIT, then mem_rvalid_i arrives -> no R or B response, and the FSM is in IDLE.
